// File: rtl/mult_share_arbiter.sv
// rtl/mult_share_arbiter.sv - round-robin arbiter sharing one registered multiplier among requesters
module mult_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 2,
    parameter int LAT   = 1
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic [N_REQ-1:0]   Req,
    input  logic [N_REQ*W-1:0] Op_A,
    input  logic [N_REQ*W-1:0] Op_B,
    output logic [N_REQ-1:0]   Grant,
    output logic [N_REQ-1:0]   Done,
    output logic [2*W-1:0]     Result,
    output logic               Busy,
    output logic [W-1:0]       Mul_A,
    output logic [W-1:0]       Mul_B,
    input  logic [2*W-1:0]     Mul_P
);

    localparam int LW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (LAT > 0) ? $clog2(LAT + 1) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t          state;
    logic [LW-1:0]   last;
    logic [CW-1:0]   cnt;
    logic [LW-1:0]   win;
    logic            found;

    // Round-robin search: first requester at or after last+1, wrapping.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!found && Req[(int'(last) + k) % N_REQ]) begin
                found = 1'b1;
                win   = LW'((int'(last) + k) % N_REQ);
            end
        end
    end

    // Busy is decoded from the state register only, so it has no input path.
    assign Busy = (state != IDLE);

    // Issue/wait/capture sequencer; Done is a single-cycle pulse on capture.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state  <= IDLE;
            Grant  <= '0;
            Done   <= '0;
            Result <= '0;
            Mul_A  <= '0;
            Mul_B  <= '0;
            cnt    <= '0;
            last   <= LW'(N_REQ - 1);
        end else begin
            Done <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        Grant <= N_REQ'(1) << win;
                        Mul_A <= Op_A[win*W +: W];
                        Mul_B <= Op_B[win*W +: W];
                        last  <= win;
                        cnt   <= CW'(LAT);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        Result <= Mul_P;
                        Done   <= Grant;
                        Grant  <= '0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb/tb_mult_share_arbiter.sv - self-checking bench for mult_share_arbiter
module tb_mult_share_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [3:0] grant;
    logic [3:0] done;
    logic [3:0] result;
    logic       busy;
    logic [1:0] mul_a;
    logic [1:0] mul_b;
    logic [3:0] mul_p = '0;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] done;
        logic [3:0] res;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        int         idx;
        logic [1:0] a;
        logic [1:0] b;
        logic [3:0] res;
    } vec_t;

    vec_t vecs[8];

    mult_share_arbiter #(.N_REQ(4), .W(2), .LAT(1)) dut (
        .Clk    (clk),
        .Rst_n  (rst_n),
        .Req    (req),
        .Op_A   (op_a),
        .Op_B   (op_b),
        .Grant  (grant),
        .Done   (done),
        .Result (result),
        .Busy   (busy),
        .Mul_A  (mul_a),
        .Mul_B  (mul_b),
        .Mul_P  (mul_p)
    );

    always #5 clk = ~clk;

    // Registered multiplier with latency 1
    always @(posedge clk) mul_p <= {2'b00, mul_a} * {2'b00, mul_b};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every Done pulse must match the oldest expected entry
    always @(negedge clk) begin
        if (done !== 4'b0000) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=%b, expected none", done);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_done", {28'd0, done}, {28'd0, e.done});
                check("sb_result", {28'd0, result}, {28'd0, e.res});
            end
        end
    end

    task automatic wait_grant(input logic [3:0] mask, input int max_cyc);
        int i;
        for (i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (grant === mask) break;
        end
        if (i == max_cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_grant: got grant=%b, expected %b", grant, mask);
        end
    endtask

    task automatic wait_idle(input int max_cyc);
        int i;
        for (i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (busy === 1'b0) break;
        end
        if (i == max_cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_idle: got busy=%b, expected 0", busy);
        end
        @(negedge clk);
    endtask

    task automatic run_single(input int idx, input logic [1:0] a, input logic [1:0] b,
                              input logic [3:0] res);
        logic [3:0] m;
        exp_t e;
        m = 4'(1) << idx;
        op_a[idx*2 +: 2] = a;
        op_b[idx*2 +: 2] = b;
        req = m;
        e.done = m;
        e.res  = res;
        sb.push_back(e);
        @(negedge clk);
        check("vec_grant", {28'd0, grant}, {28'd0, m});
        check("vec_mul_a", {30'd0, mul_a}, {30'd0, a});
        check("vec_mul_b", {30'd0, mul_b}, {30'd0, b});
        req = 4'b0000;
        @(negedge clk);
        check("vec_grant_hold", {28'd0, grant}, {28'd0, m});
        check("vec_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("vec_done", {28'd0, done}, {28'd0, m});
        check("vec_result", {28'd0, result}, {28'd0, res});
        check("vec_grant_drop", {28'd0, grant}, 32'd0);
        check("vec_busy_drop", {31'd0, busy}, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] gseq[4];
        logic [3:0] gexp[4];
        logic [3:0] prev_g;
        int         ng;
        exp_t       e;

        vecs[0] = '{0, 2'd1, 2'd2, 4'd2};
        vecs[1] = '{1, 2'd3, 2'd3, 4'd9};
        vecs[2] = '{2, 2'd0, 2'd3, 4'd0};
        vecs[3] = '{3, 2'd2, 2'd3, 4'd6};
        vecs[4] = '{0, 2'd3, 2'd2, 4'd6};
        vecs[5] = '{3, 2'd1, 2'd1, 4'd1};
        vecs[6] = '{2, 2'd3, 2'd0, 4'd0};
        vecs[7] = '{1, 2'd2, 2'd2, 4'd4};

        // Reset with all requesters asking
        rst_n = 1'b0;
        req   = 4'b1111;
        op_a  = {2'b00, 2'b11, 2'b10, 2'b01};
        op_b  = {2'b11, 2'b11, 2'b10, 2'b10};
        repeat (3) @(negedge clk);
        check("rst_grant", {28'd0, grant}, 32'd0);
        check("rst_done", {28'd0, done}, 32'd0);
        check("rst_result", {28'd0, result}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_mul_a", {30'd0, mul_a}, 32'd0);
        check("rst_mul_b", {30'd0, mul_b}, 32'd0);

        e = '{4'b0001, 4'd2};  sb.push_back(e);
        e = '{4'b0010, 4'd4};  sb.push_back(e);
        e = '{4'b0100, 4'd9};  sb.push_back(e);
        e = '{4'b1000, 4'd0};  sb.push_back(e);
        rst_n = 1'b1;

        // All four continuous: grants k at c=1+3k,2+3k; done at c=3+3k
        for (int c = 1; c <= 13; c++) begin
            logic [3:0] eg;
            logic [3:0] ed;
            @(negedge clk);
            eg = 4'b0000;
            ed = 4'b0000;
            for (int k = 0; k < 4; k++) begin
                if (c == 1 + 3*k || c == 2 + 3*k) eg = 4'(1) << k;
                if (c == 3 + 3*k) ed = 4'(1) << k;
            end
            check($sformatf("rr_grant_c%0d", c), {28'd0, grant}, {28'd0, eg});
            check($sformatf("rr_done_c%0d", c), {28'd0, done}, {28'd0, ed});
            req = req & ~grant;
        end
        req = 4'b0000;

        // Fairness between requesters 0 and 2
        op_a[1:0] = 2'd2; op_b[1:0] = 2'd3;
        op_a[5:4] = 2'd3; op_b[5:4] = 2'd1;
        e = '{4'b0001, 4'd6}; sb.push_back(e);
        e = '{4'b0100, 4'd3}; sb.push_back(e);
        e = '{4'b0001, 4'd6}; sb.push_back(e);
        e = '{4'b0100, 4'd3}; sb.push_back(e);
        gexp = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
        gseq = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
        req = 4'b0101;
        prev_g = 4'b0000;
        ng = 0;
        for (int c = 0; c < 30 && ng < 4; c++) begin
            @(negedge clk);
            if (grant !== 4'b0000 && prev_g === 4'b0000) begin
                gseq[ng] = grant;
                ng++;
                if (ng == 4) req = 4'b0000;
            end
            prev_g = grant;
        end
        for (int i = 0; i < 4; i++)
            check($sformatf("fair_grant_%0d", i), {28'd0, gseq[i]}, {28'd0, gexp[i]});
        wait_idle(10);

        // Operand change after issue does not affect the product
        op_a[3:2] = 2'd3;
        op_b[3:2] = 2'd3;
        e = '{4'b0010, 4'd9}; sb.push_back(e);
        req = 4'b0010;
        wait_grant(4'b0010, 10);
        req = 4'b0000;
        @(negedge clk);
        op_a[3:2] = 2'd1;
        check("late_op_mul_a", {30'd0, mul_a}, 32'd3);
        wait_idle(10);
        check("late_op_result", {28'd0, result}, 32'd9);

        // Reset during WAIT discards the transaction
        op_a[5:4] = 2'd2;
        op_b[5:4] = 2'd2;
        req = 4'b0100;
        wait_grant(4'b0100, 10);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_grant", {28'd0, grant}, 32'd0);
        check("midrst_mul_a", {30'd0, mul_a}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("midrst_done", {28'd0, done}, 32'd0);
        e = '{4'b0100, 4'd4}; sb.push_back(e);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_regrant", {28'd0, grant}, 32'h4);
        req = 4'b0000;
        wait_idle(10);

        // Table-driven single transactions
        for (int i = 0; i < 8; i++)
            run_single(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].res);

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
